// File: rtl/aurora_pkg.sv
// Shared Aurora-style types and 8b/10b control symbols for the TX lane path.
package aurora_pkg;

  localparam int AXI_DATA_SIZE = 32;
  localparam int LANE_W        = 16;

  typedef enum logic [2:0] {
    OS_NONE,
    OS_I,
    OS_SCP,
    OS_ECP,
    OS_CC
  } ordered_sets_e;

  typedef struct packed {
    ordered_sets_e              os;
    logic [AXI_DATA_SIZE-1:0]   data;
  } os_word_t;

  localparam int OS_WORD_W = $bits(os_word_t);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  localparam logic [6:0] LFSR_SEED = 7'h7F;

  // Two LFSR bits pick one idle byte: 0x -> /K/, 10 -> /R/, 11 -> /A/.
  function automatic logic [7:0] idle_byte(input logic [1:0] sel);
    return sel[1] ? (sel[0] ? K28_3 : K28_0) : K28_5;
  endfunction

endpackage

// File: rtl/tx_symbol_encoder_cc_elastic_buf.sv
// First-word-fall-through sync FIFO that parks upstream words while CC symbols occupy the lanes.
module cc_elastic_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push, do_pop;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign level_o    = level_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && (!full_o || pop_i);
  assign do_pop     = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop)
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
      assert (!(push_i && full_o && !pop_i));
    end
  end

endmodule

// File: rtl/tx_symbol_encoder.sv
// Maps {ordered_sets, data} words onto per-lane K/D symbol words with LFSR idles and periodic CC.
// One-cycle registered latency; words arriving during CC are parked in the elastic buffer.
module tx_symbol_encoder
  import aurora_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int CC_PERIOD = 10000,
  parameter int CC_LEN    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          single_lane,
  input  ordered_sets_e                 ordered_sets,
  input  logic [AXI_DATA_SIZE-1:0]      data_in,
  output logic [LANE_W*NUM_LANES-1:0]   tx_data,
  output logic [2*NUM_LANES-1:0]        tx_charisk,
  output logic                          cc_active,
  output logic [$clog2(CC_LEN+1)-1:0]   buf_level
);
  localparam int CNT_W = $clog2(CC_PERIOD);
  localparam int LVL_W = $clog2(CC_LEN+1);
  localparam int CCN_W = (CC_LEN > 2) ? $clog2(CC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CC_PERIOD-1);
  localparam logic [CCN_W-1:0] CCN_LAST = CCN_W'(CC_LEN-2);

  typedef enum logic [1:0] {PASS, CC_SEND, DRAIN} state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cc_cnt_q, cc_cnt_d;
  logic [CCN_W-1:0]              ccn_q, ccn_d;
  logic [6:0]                    lfsr_q, lfsr_d;
  logic                          half_q, half_d;
  logic [LANE_W*NUM_LANES-1:0]   tx_data_q, tx_data_d;
  logic [2*NUM_LANES-1:0]        tx_charisk_q, tx_charisk_d;
  logic                          cc_active_q;

  os_word_t                      in_word, sel_word;
  logic [OS_WORD_W-1:0]          fifo_head;
  logic [LVL_W-1:0]              fifo_level;
  logic                          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic                          in_idle, cc_due, cc_start, emit_cc;
  logic [LANE_W-1:0]             idle_w;

  assign in_word = '{os: ordered_sets, data: data_in};
  assign in_idle = (ordered_sets == OS_I);
  assign cc_due  = (cc_cnt_q == CNT_MAX);
  assign idle_w  = {idle_byte(lfsr_q[1:0]), idle_byte(lfsr_q[3:2])};

  cc_elastic_buf #(.W(OS_WORD_W), .DEPTH(CC_LEN)) u_buf (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (fifo_push),
    .push_dat_i (in_word),
    .pop_i      (fifo_pop),
    .head_dat_o (fifo_head),
    .level_o    (fifo_level),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  always_comb begin
    state_d   = state_q;
    ccn_d     = ccn_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    cc_start  = 1'b0;
    emit_cc   = 1'b0;
    sel_word  = in_word;
    case (state_q)
      PASS: begin
        if (cc_due && in_idle && fifo_empty) begin
          cc_start = 1'b1;
          emit_cc  = 1'b1;
          ccn_d    = '0;
          state_d  = CC_SEND;
        end
      end
      CC_SEND: begin
        emit_cc   = 1'b1;
        fifo_push = !in_idle && !fifo_full;
        ccn_d     = ccn_q + CCN_W'(1);
        if (ccn_q == CCN_LAST)
          state_d = (fifo_empty && !fifo_push) ? PASS : DRAIN;
      end
      DRAIN: begin
        fifo_pop  = 1'b1;
        sel_word  = os_word_t'(fifo_head);
        fifo_push = !in_idle;
        if (fifo_level == LVL_W'(1) && !fifo_push)
          state_d = PASS;
      end
      default: state_d = PASS;
    endcase
  end

  // Only pass-through idles consume LFSR state; buffered words never hold OS_I.
  always_comb begin
    cc_cnt_d     = cc_start ? '0 : (cc_due ? cc_cnt_q : cc_cnt_q + CNT_W'(1));
    half_d       = !emit_cc && (sel_word.os == OS_NONE) && !half_q;
    lfsr_d       = (!emit_cc && sel_word.os == OS_I) ? {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]} : lfsr_q;
    tx_data_d    = '0;
    tx_charisk_d = '1;
    for (int l = 0; l < NUM_LANES; l++) begin
      tx_data_d[l*LANE_W +: LANE_W] = idle_w;
      if (emit_cc) begin
        tx_data_d[l*LANE_W +: LANE_W] = {K28_7, K28_7};
      end else begin
        case (sel_word.os)
          OS_SCP: tx_data_d[l*LANE_W +: LANE_W] = {K28_2, K27_7};
          OS_ECP: tx_data_d[l*LANE_W +: LANE_W] = {K29_7, K30_7};
          OS_CC:  tx_data_d[l*LANE_W +: LANE_W] = {K28_7, K28_7};
          OS_NONE: begin
            if (!single_lane) begin
              tx_data_d[l*LANE_W +: LANE_W] = sel_word.data[l*LANE_W +: LANE_W];
              tx_charisk_d[2*l +: 2]        = 2'b00;
            end else if (l == 0) begin
              tx_data_d[l*LANE_W +: LANE_W] = half_q ? sel_word.data[0 +: LANE_W]
                                                     : sel_word.data[LANE_W +: LANE_W];
              tx_charisk_d[2*l +: 2]        = 2'b00;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PASS;
      cc_cnt_q     <= '0;
      ccn_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      half_q       <= 1'b0;
      tx_data_q    <= {NUM_LANES{K28_5, K28_5}};
      tx_charisk_q <= '1;
      cc_active_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cc_cnt_q     <= cc_cnt_d;
      ccn_q        <= ccn_d;
      lfsr_q       <= lfsr_d;
      half_q       <= half_d;
      tx_data_q    <= tx_data_d;
      tx_charisk_q <= tx_charisk_d;
      cc_active_q  <= emit_cc;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_charisk = tx_charisk_q;
  assign cc_active  = cc_active_q;
  assign buf_level  = fifo_level;

endmodule

// File: tb/tb_tx_symbol_encoder.sv
// Directed vectors for tx_symbol_encoder with CC_PERIOD=16, CC_LEN=4, two lanes.
module tb_tx_symbol_encoder;
  import aurora_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          single_lane = 1'b0;
  ordered_sets_e os = OS_I;
  logic [31:0]   din = '0;
  logic [31:0]   tx_data;
  logic [3:0]    tx_charisk;
  logic          cc_active;
  logic [2:0]    buf_level;

  int            checks = 0;
  int            errors = 0;
  logic [6:0]    m_lfsr;
  logic [31:0]   e;

  typedef struct {
    logic          r;
    ordered_sets_e o;
    logic [31:0]   d;
    logic [31:0]   ed;
    logic [3:0]    ek;
    logic          ecc;
    logic [2:0]    el;
  } vec_t;

  vec_t tv[10];

  always #5 clk = ~clk;

  tx_symbol_encoder #(.NUM_LANES(2), .CC_PERIOD(16), .CC_LEN(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .single_lane  (single_lane),
    .ordered_sets (os),
    .data_in      (din),
    .tx_data      (tx_data),
    .tx_charisk   (tx_charisk),
    .cc_active    (cc_active),
    .buf_level    (buf_level)
  );

  task automatic step(input logic r, input ordered_sets_e o, input logic [31:0] d);
    rst = r;
    os  = o;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] ed, input logic [3:0] ek,
                     input logic ecc, input logic [2:0] el);
    checks++;
    if (tx_data !== ed || tx_charisk !== ek || cc_active !== ecc || buf_level !== el) begin
      errors++;
      $display("FAIL %s: got data=%h k=%h cc=%b lvl=%0d, want data=%h k=%h cc=%b lvl=%0d",
               name, tx_data, tx_charisk, cc_active, buf_level, ed, ek, ecc, el);
    end
  endtask

  function automatic logic [7:0] ib(input logic [1:0] s);
    return s[1] ? (s[0] ? 8'h7C : 8'h1C) : 8'hBC;
  endfunction

  function automatic logic is_idle(input logic [7:0] b);
    return (b == 8'hBC) || (b == 8'h1C) || (b == 8'h7C);
  endfunction

  task automatic exp_idle(output logic [31:0] x);
    x      = {2{ib(m_lfsr[1:0]), ib(m_lfsr[3:2])}};
    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  endtask

  task automatic chk_single(input string name, input logic [15:0] l0);
    checks++;
    if (tx_data[15:0] !== l0 || tx_charisk !== 4'b1100 || !is_idle(tx_data[31:24]) ||
        !is_idle(tx_data[23:16]) || cc_active !== 1'b0 || buf_level !== 3'd0) begin
      errors++;
      $display("FAIL %s: got data=%h k=%h cc=%b lvl=%0d, want lane0=%h k=c lane1 idle",
               name, tx_data, tx_charisk, cc_active, buf_level, l0);
    end
  endtask

  initial begin
    // Reset, idle start-up, then SCP / data / ECP pass-through.
    tv[0] = '{1'b1, OS_I,    32'h0,        32'hBCBCBCBC, 4'hF, 1'b0, 3'd0};
    tv[1] = '{1'b0, OS_I,    32'h0,        32'h7C7C7C7C, 4'hF, 1'b0, 3'd0};
    tv[2] = '{1'b0, OS_I,    32'h0,        32'h1C7C1C7C, 4'hF, 1'b0, 3'd0};
    tv[3] = '{1'b0, OS_SCP,  32'h0,        32'h5CFB5CFB, 4'hF, 1'b0, 3'd0};
    tv[4] = '{1'b0, OS_SCP,  32'h0,        32'h5CFB5CFB, 4'hF, 1'b0, 3'd0};
    tv[5] = '{1'b0, OS_NONE, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 1'b0, 3'd0};
    tv[6] = '{1'b0, OS_NONE, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 1'b0, 3'd0};
    tv[7] = '{1'b0, OS_NONE, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 1'b0, 3'd0};
    tv[8] = '{1'b0, OS_ECP,  32'h0,        32'hFDFEFDFE, 4'hF, 1'b0, 3'd0};
    tv[9] = '{1'b0, OS_ECP,  32'h0,        32'hFDFEFDFE, 4'hF, 1'b0, 3'd0};
    for (int i = 0; i < 10; i++) begin
      step(tv[i].r, tv[i].o, tv[i].d);
      chk($sformatf("vec%0d", i), tv[i].ed, tv[i].ek, tv[i].ecc, tv[i].el);
    end

    // Idles held: CC on cycles 16-19 and again 32-35.
    step(1'b1, OS_I, '0);
    m_lfsr = 7'h7F;
    for (int k = 1; k <= 36; k++) begin
      step(1'b0, OS_I, '0);
      if ((k >= 16 && k <= 19) || (k >= 32 && k <= 35))
        chk($sformatf("cc_hold_%0d", k), 32'hFCFCFCFC, 4'hF, 1'b1, 3'd0);
      else begin
        exp_idle(e);
        chk($sformatf("idle_hold_%0d", k), e, 4'hF, 1'b0, 3'd0);
      end
    end

    // Frame starts during CC: buffered, then drained by trailing idles.
    step(1'b1, OS_I, '0);
    m_lfsr = 7'h7F;
    for (int k = 1; k <= 15; k++) begin
      step(1'b0, OS_I, '0);
      exp_idle(e);
      chk($sformatf("pre_cc_%0d", k), e, 4'hF, 1'b0, 3'd0);
    end
    step(1'b0, OS_I, '0);                chk("cc_c1", 32'hFCFCFCFC, 4'hF, 1'b1, 3'd0);
    step(1'b0, OS_SCP, '0);              chk("cc_c2", 32'hFCFCFCFC, 4'hF, 1'b1, 3'd1);
    step(1'b0, OS_NONE, 32'hAAAA0001);   chk("cc_c3", 32'hFCFCFCFC, 4'hF, 1'b1, 3'd2);
    step(1'b0, OS_NONE, 32'hBBBB0002);   chk("cc_c4", 32'hFCFCFCFC, 4'hF, 1'b1, 3'd3);
    step(1'b0, OS_NONE, 32'hCCCC0003);   chk("drain_scp", 32'h5CFB5CFB, 4'hF, 1'b0, 3'd3);
    step(1'b0, OS_NONE, 32'hDDDD0004);   chk("drain_a", 32'hAAAA0001, 4'h0, 1'b0, 3'd3);
    step(1'b0, OS_ECP, '0);              chk("drain_b", 32'hBBBB0002, 4'h0, 1'b0, 3'd3);
    step(1'b0, OS_I, '0);                chk("drain_c", 32'hCCCC0003, 4'h0, 1'b0, 3'd2);
    step(1'b0, OS_I, '0);                chk("drain_d", 32'hDDDD0004, 4'h0, 1'b0, 3'd1);
    step(1'b0, OS_I, '0);                chk("drain_ecp", 32'hFDFEFDFE, 4'hF, 1'b0, 3'd0);
    step(1'b0, OS_I, '0);
    exp_idle(e);
    chk("drain_idle", e, 4'hF, 1'b0, 3'd0);

    // CC becomes due mid-frame and waits for the first idle.
    step(1'b1, OS_I, '0);
    m_lfsr = 7'h7F;
    for (int k = 1; k <= 2; k++) begin
      step(1'b0, OS_I, '0);
      exp_idle(e);
      chk($sformatf("due_pre_%0d", k), e, 4'hF, 1'b0, 3'd0);
    end
    step(1'b0, OS_SCP, '0);
    chk("due_scp", 32'h5CFB5CFB, 4'hF, 1'b0, 3'd0);
    for (int k = 4; k <= 20; k++) begin
      step(1'b0, OS_NONE, 32'hA0000000 + k);
      chk($sformatf("due_data_%0d", k), 32'hA0000000 + k, 4'h0, 1'b0, 3'd0);
    end
    step(1'b0, OS_ECP, '0);
    chk("due_ecp", 32'hFDFEFDFE, 4'hF, 1'b0, 3'd0);
    for (int k = 22; k <= 25; k++) begin
      step(1'b0, OS_I, '0);
      chk($sformatf("due_cc_%0d", k), 32'hFCFCFCFC, 4'hF, 1'b1, 3'd0);
    end
    step(1'b0, OS_I, '0);
    exp_idle(e);
    chk("due_post_idle", e, 4'hF, 1'b0, 3'd0);

    // Single-lane half-word sequencing, then a mid-frame reset.
    step(1'b1, OS_I, '0);
    m_lfsr = 7'h7F;
    single_lane = 1'b1;
    step(1'b0, OS_I, '0);
    exp_idle(e);
    chk("sl_idle", e, 4'hF, 1'b0, 3'd0);
    step(1'b0, OS_NONE, 32'h12345678);   chk_single("sl_hi0", 16'h1234);
    step(1'b0, OS_NONE, 32'h12345678);   chk_single("sl_lo0", 16'h5678);
    step(1'b0, OS_NONE, 32'h9ABCDEF0);   chk_single("sl_hi1", 16'h9ABC);
    step(1'b0, OS_NONE, 32'h9ABCDEF0);   chk_single("sl_lo1", 16'hDEF0);
    step(1'b1, OS_NONE, 32'h9ABCDEF0);
    chk("sl_reset", 32'hBCBCBCBC, 4'hF, 1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
